// File: rtl/fifo_wr_adapter_if.sv
// Stream and FIFO write-port signals of the FIFO write adapter.
// master: upstream source plus FIFO full flag; slave: the adapter itself.
interface fifo_wr_adapter_if #(
   parameter int DSIZE = 8
) ();
   logic             s_valid;
   logic [DSIZE-1:0] s_data;
   logic             s_last;
   logic             s_ready;
   logic             wfull;
   logic             winc;
   logic [DSIZE-1:0] wdata;

   modport master (
      output s_valid, s_data, s_last, wfull,
      input  s_ready, winc, wdata
   );

   modport slave (
      input  s_valid, s_data, s_last, wfull,
      output s_ready, winc, wdata
   );
endinterface

// File: rtl/fifo_wr_adapter.sv
// Write-side front end of the async FIFO: a valid/ready packet stream is
// turned into FIFO write strobes through a two-entry output/skid buffer.
// Packets longer than MAX_PKT are truncated (last kept word marked as the
// packet end) and the remainder is swallowed, with a one-cycle error pulse.
module fifo_wr_adapter #(
   parameter int DSIZE   = 8,
   parameter int MAX_PKT = 16,
   parameter int LCNT_W  = 8,
   parameter int STAT_W  = 16
) (
   input  logic              wclk,
   input  logic              dirclr_n,
   fifo_wr_adapter_if.slave  bus,
   output logic              pkt_err,
   output logic              in_pkt,
   output logic [STAT_W-1:0] wcount,
   output logic [STAT_W-1:0] pcount
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LCNT_W-1:0]  len_q, len_d;
   logic               s_ready_q, s_ready_d;
   logic               pkt_err_q, pkt_err_d;
   logic               ov_q, ov_d;
   logic [DSIZE-1:0]   od_q, od_d;
   logic               ol_q, ol_d;
   logic               sv_q, sv_d;
   logic [DSIZE-1:0]   sd_q, sd_d;
   logic               sl_q, sl_d;
   logic [STAT_W-1:0]  wcount_q, wcount_d;
   logic [STAT_W-1:0]  pcount_q, pcount_d;

   logic               accept_s;
   logic               buf_in_s;
   logic               force_last_s;
   logic               in_last_s;
   logic               winc_s;

   assign accept_s  = bus.s_valid & s_ready_q;
   assign winc_s    = ov_q & ~bus.wfull;
   // Words accepted while dropping an over-length tail never enter the buffer.
   assign buf_in_s  = accept_s & (state_q != ST_DROP);
   assign in_last_s = bus.s_last | force_last_s;

   // Packet-length FSM: next state, length counter and over-length detection.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      pkt_err_d    = 1'b0;
      force_last_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && !bus.s_last) begin
               len_d   = LCNT_W'(1);
               state_d = ST_PASS;
            end else begin
               len_d   = {LCNT_W{1'b0}};
            end
         end
         ST_PASS: begin
            if (accept_s) begin
               if (bus.s_last) begin
                  state_d = ST_IDLE;
                  len_d   = {LCNT_W{1'b0}};
               end else if ((len_q + LCNT_W'(1)) == LCNT_W'(MAX_PKT)) begin
                  // This word reaches the limit: keep it as the packet end.
                  state_d      = ST_DROP;
                  len_d        = {LCNT_W{1'b0}};
                  force_last_s = 1'b1;
                  pkt_err_d    = 1'b1;
               end else begin
                  len_d = len_q + LCNT_W'(1);
               end
            end else begin
               len_d = len_q;
            end
         end
         ST_DROP: begin
            if (accept_s && bus.s_last) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            len_d   = {LCNT_W{1'b0}};
         end
      endcase
   end

   // Output/skid buffer: output drains first, skid refills it, order preserved.
   always_comb begin
      ov_d = ov_q;
      od_d = od_q;
      ol_d = ol_q;
      sv_d = sv_q;
      sd_d = sd_q;
      sl_d = sl_q;
      if (winc_s) begin
         if (sv_q) begin
            ov_d = 1'b1;
            od_d = sd_q;
            ol_d = sl_q;
            sv_d = 1'b0;
         end else if (buf_in_s) begin
            ov_d = 1'b1;
            od_d = bus.s_data;
            ol_d = in_last_s;
         end else begin
            ov_d = 1'b0;
         end
      end else if (!ov_q) begin
         if (buf_in_s) begin
            ov_d = 1'b1;
            od_d = bus.s_data;
            ol_d = in_last_s;
         end else begin
            ov_d = 1'b0;
         end
      end else begin
         // Output stalled: at most one word lands in the skid entry.
         if (buf_in_s) begin
            sv_d = 1'b1;
            sd_d = bus.s_data;
            sl_d = in_last_s;
         end else begin
            sv_d = sv_q;
         end
      end
   end

   // Ready and statistics next-state: dropping never stalls upstream.
   always_comb begin
      if (state_d == ST_DROP) begin
         s_ready_d = 1'b1;
      end else begin
         s_ready_d = ~sv_d;
      end
      if (winc_s) begin
         wcount_d = wcount_q + STAT_W'(1);
      end else begin
         wcount_d = wcount_q;
      end
      if (winc_s && ol_q) begin
         pcount_d = pcount_q + STAT_W'(1);
      end else begin
         pcount_d = pcount_q;
      end
   end

   // State, buffer and statistics registers with asynchronous clear.
   always_ff @(posedge wclk or negedge dirclr_n) begin
      if (!dirclr_n) begin
         state_q   <= ST_IDLE;
         len_q     <= {LCNT_W{1'b0}};
         s_ready_q <= 1'b0;
         pkt_err_q <= 1'b0;
         ov_q      <= 1'b0;
         od_q      <= {DSIZE{1'b0}};
         ol_q      <= 1'b0;
         sv_q      <= 1'b0;
         sd_q      <= {DSIZE{1'b0}};
         sl_q      <= 1'b0;
         wcount_q  <= {STAT_W{1'b0}};
         pcount_q  <= {STAT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         s_ready_q <= s_ready_d;
         pkt_err_q <= pkt_err_d;
         ov_q      <= ov_d;
         od_q      <= od_d;
         ol_q      <= ol_d;
         sv_q      <= sv_d;
         sd_q      <= sd_d;
         sl_q      <= sl_d;
         wcount_q  <= wcount_d;
         pcount_q  <= pcount_d;
      end
   end

   assign bus.s_ready = s_ready_q;
   assign bus.winc    = winc_s;
   assign bus.wdata   = od_q;
   assign pkt_err     = pkt_err_q;
   assign in_pkt      = (state_q != ST_IDLE);
   assign wcount      = wcount_q;
   assign pcount      = pcount_q;

endmodule

// File: doc/fifo_wr_adapter.md
Name: fifo_wr_adapter

Overview:
- Write-side front end of the async FIFO. Runs on wclk and turns a valid/ready packet stream into FIFO write strobes.
- Drives winc/wdata into the FIFO write port and honours its wfull.
- Two-entry skid/output buffer gives full throughput with a registered s_ready.
- Enforces a maximum packet length: over-length tails are dropped and flagged.
- Keeps word and packet statistics.

Parameters:
DSIZE, 8, data width; must equal the FIFO DSIZE
MAX_PKT, 16, maximum words per packet (>=2)
LCNT_W, 8, width of the per-packet length counter (2^LCNT_W > MAX_PKT)
STAT_W, 16, width of the wcount and pcount statistics counters

Ports:
wclk  in  1  write-domain clock, rising edge
dirclr_n  in  1  reset, asynchronous, active-low
s_valid  in  1  upstream word valid
s_data  in  DSIZE  upstream word
s_last  in  1  marks the final word of a packet
s_ready  out  1  registered; adapter can accept a word
wfull  in  1  FIFO full, synchronous to wclk
winc  out  1  FIFO write strobe
wdata  out  DSIZE  FIFO write data
pkt_err  out  1  one-cycle pulse, over-length packet detected
in_pkt  out  1  high between first accepted word and the s_last word
wcount  out  STAT_W  words written to the FIFO, wraps
pcount  out  STAT_W  packets completed (last word written), wraps

Behaviour:
- Reset (dirclr_n low, async):
  - s_ready=0, winc=0, wdata=0, pkt_err=0, in_pkt=0, wcount=0, pcount=0.
  - Both buffer entries empty; length counter 0; state IDLE.
  - s_ready rises on the first wclk edge after reset deassertion.
- Handshake:
  - Transfer occurs when s_valid & s_ready at a wclk edge.
  - s_ready is registered, equal to "skid entry empty" for the next cycle.
- Buffer:
  - Output register (ov, od, ol) feeds the FIFO; skid register (sv, sd, sl) catches the word accepted while the output is stalled.
  - Order is strictly preserved: output first, then skid.
- Write strobe:
  - winc = ov & ~wfull (combinational on wfull); wdata = od.
  - When winc=1 the output register is consumed at that edge and refilled from skid, else from input, else cleared.
- Latency: a word accepted at edge N appears on wdata with winc high in cycle N+1 if wfull=0.
- Throughput: one word per cycle sustained while wfull=0.
- wfull high: winc=0, od held. At most one more word is accepted (into skid), then s_ready=0.
- States:
  - IDLE: no packet open. An accepted word sets LEN=1 and moves to PASS. An accepted word with s_last completes a 1-word packet and stays in IDLE.
  - PASS: each accepted non-last word increments LEN.
    - s_last accepted -> IDLE, LEN=0.
    - An accepted non-last word that makes LEN==MAX_PKT -> DROP, with pkt_err=1 next cycle. That word is buffered and written with ol forced to 1, so the packet is truncated to exactly MAX_PKT words.
  - DROP: words are accepted (s_ready=1 regardless of buffer state) and discarded, never buffered. The accepted s_last word is also discarded -> IDLE.
- in_pkt = (state != IDLE).
- Statistics:
  - wcount +1 on each winc.
  - pcount +1 on each winc whose ol=1.
  - Both wrap modulo 2^STAT_W.
- Simultaneous events:
  - Accept and write in the same cycle: both happen and occupancy is unchanged.
  - s_last on the word that reaches MAX_PKT: a normal completion, no pkt_err, -> IDLE.
  - Word arriving while in DROP and wfull=1: still discarded, no stall.
- Reset mid-operation: the buffered words are lost. The FIFO is reset by the same dirclr_n domain logic, so no partial packet needs recovery.

Test Plan:
- Reset then single packet: after dirclr_n deasserts, send 3 words 0x11,0x22,0x33 (last on 0x33), wfull=0 -> winc high on 3 consecutive cycles starting 1 cycle after the first accept; wdata 0x11,0x22,0x33; wcount=3, pcount=1, in_pkt back to 0.
- Backpressure: stream 0xA0..0xA7 continuously; hold wfull=1 for 4 cycles mid-stream -> s_ready drops 1 cycle after wfull is seen, after one extra word is accepted; no word lost or duplicated; the FIFO sees 0xA0..0xA7 in order; wcount=8.
- Over-length, MAX_PKT=4: send a 7-word packet 0x01..0x07 -> 0x01..0x04 written, 0x04 counts as the packet end; pkt_err pulses once, the cycle after 0x04 is accepted; 0x05..0x07 consumed with s_ready=1 and not written; pcount=1, wcount=4.
- Exact limit, MAX_PKT=4: 4-word packet with s_last on word 4 -> all 4 written, pkt_err stays 0, pcount=1.
- Back-to-back 1-word packets 0x5A,0x5B,0x5C, all with s_last -> 3 consecutive winc cycles, pcount=3, in_pkt never asserts.
- Reset mid-packet: assert dirclr_n after 2 of 5 words while wfull=1 -> all outputs return to reset values immediately; the next packet after release is written cleanly starting at wcount=0.
